vga_timing_gen: RTL

- Parametrised display timing generator, next generation of the fixed 640x480 `dtg` in the VGA path.
- Generates the raster counters plus hsync, vsync and video_on for any resolution, and adds:
  - a pixel-clock enable,
  - programmable sync polarity,
  - line_start and frame_start strobes,
  - a frame counter,
  - a sticky vblank interrupt with ack, for the CPU to synchronise rope/icon updates.
- Sits between the 75 MHz video clock domain and the icon/colorizer logic.

---
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its video consumers.
// Latency: n/a (wires only).
// Backpressure: none; pix_en gates the raster, irq_ack clears the interrupt.
// Ports: pix_en/irq_ack drive the generator; the sync, decode, counter, strobe
// and interrupt outputs come back from it.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 11,
  parameter int FRAME_W = 16
);
  logic               pix_en;
  logic               irq_ack;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic [CNT_W-1:0]   pixel_column;
  logic [CNT_W-1:0]   pixel_row;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  logic               vblank_irq;

  // Generator side.
  modport master (
    input  pix_en, irq_ack,
    output hsync, vsync, video_on, pixel_column, pixel_row,
           line_start, frame_start, frame_cnt, vblank_irq
  );

  // Consumer / CPU side.
  modport slave (
    output pix_en, irq_ack,
    input  hsync, vsync, video_on, pixel_column, pixel_row,
           line_start, frame_start, frame_cnt, vblank_irq
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised display timing generator: raster counters, syncs, strobes, frame count, vblank irq.
// Latency: every output is a flop, aligned with the (h,v) it presents; one clk from pix_en to step.
// Backpressure: pix_en=0 freezes the raster and zeroes strobes; irq_ack clears the sticky irq.
// Ports: clk, rstn (sync, active-low), vif (master modport): pix_en, irq_ack in;
// hsync, vsync, video_on, pixel_column, pixel_row, line_start, frame_start,
// frame_cnt, vblank_irq out.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 144,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 11,
  parameter int FRAME_W  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: every porch and sync width must be >= 1");
  end
  if (CNT_W < $clog2(MAX_TOTAL)) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   v_q, v_d;
  logic               run_q, run_d;
  logic               video_on_q, video_on_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               irq_q, irq_d;
  logic               h_wrap, v_wrap, irq_set;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    run_d         = run_q;
    video_on_d    = video_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    irq_set       = 1'b0;

    if (vif.pix_en) begin
      run_d = 1'b1;
      // The first enabled step after reset only presents (0,0) with its
      // decodes; the counters already sit at (0,0), so no wrap and no strobe.
      if (run_q) begin
        h_d = h_wrap ? '0 : h_q + CNT_W'(1);
        if (h_wrap) begin
          v_d = v_wrap ? '0 : v_q + CNT_W'(1);
        end
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
        if (h_wrap && v_wrap) begin
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
      end else begin
        h_d = '0;
        v_d = '0;
      end
      // Decode from the next position so decodes land together with it.
      video_on_d = (h_d < H_ACT_C) && (v_d < V_ACT_C);
      hsync_d    = ((h_d >= HS_BEG_C) && (h_d < HS_END_C)) ? HS_POL : ~HS_POL;
      vsync_d    = ((v_d >= VS_BEG_C) && (v_d < VS_END_C)) ? VS_POL : ~VS_POL;
      irq_set    = (h_d == '0) && (v_d == V_ACT_C);
    end

    // Ack is a CPU action and is honoured even while the raster is paused;
    // a set on the same edge takes priority so no vblank is ever lost.
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (vif.irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      h_q           <= '0;
      v_q           <= '0;
      run_q         <= 1'b0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      irq_q         <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      run_q         <= run_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      irq_q         <= irq_d;
    end
  end

  assign vif.pixel_column = h_q;
  assign vif.pixel_row    = v_q;
  assign vif.video_on     = video_on_q;
  assign vif.hsync        = hsync_q;
  assign vif.vsync        = vsync_q;
  assign vif.line_start   = line_start_q;
  assign vif.frame_start  = frame_start_q;
  assign vif.frame_cnt    = frame_cnt_q;
  assign vif.vblank_irq   = irq_q;

endmodule
